// File: rtl/regfile_scoreboard_pkg.sv
// Shared defaults and encodings for the parametrised register file with scoreboard.
//   DEF_*      : default widths and port counts used by regfile_scoreboard
//   INIT_ZERO  : reset fills the array with zeros
//   INIT_INDEX : reset fills reg[i] with i (debug pattern)
package regfile_scoreboard_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_NUM_RD = 4;
  localparam int unsigned DEF_NUM_WR = 2;

  localparam int unsigned INIT_ZERO  = 0;
  localparam int unsigned INIT_INDEX = 1;

endpackage

// File: rtl/regfile_rd_bypass.sv
// One read port of the register file: zero-register masking, optional same-cycle
// write bypass and operand-ready (valid) generation.
// Ports:
//   rd_en, rd_addr      : read request for this port
//   wr_en/wr_addr/wr_data : all writeback ports, packed (port k at [k*W +: W])
//   arr_data, pending   : stored array value and pending bit for rd_addr
//   rd_data, rd_valid   : read result and operand-ready flag
//   hit                 : a write port matched this address this cycle (BYPASS only)
module regfile_rd_bypass
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned NUM_WR = DEF_NUM_WR,
  parameter int unsigned BYPASS = 1
) (
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0]        arr_data,
  input  logic                     pending,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     hit
);

  logic [DATA_W-1:0] byp_data;
  logic              addr_zero;

  assign addr_zero = (rd_addr == '0);

  // Ascending scan so the highest-index matching write port wins.
  always_comb begin
    hit      = 1'b0;
    byp_data = '0;
    if (BYPASS != 0) begin
      for (int k = 0; k < int'(NUM_WR); k++) begin
        if (wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] == rd_addr)) begin
          hit      = 1'b1;
          byp_data = wr_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_en && !addr_zero) begin
      rd_data = hit ? byp_data : arr_data;
    end
  end

  assign rd_valid = rd_en & (addr_zero | ~pending | hit);

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised GPR + HI/LO register file with a per-register pending scoreboard.
// Issue reads operands and allocates destinations; writeback writes and clears pending.
// Ports:
//   clk, rst_                    : clock, synchronous active-high reset
//   rd_en/rd_addr -> rd_data/rd_valid : NUM_RD combinational read ports
//   alloc_en/alloc_addr          : mark destinations pending
//   wr_en/wr_addr/wr_data        : NUM_WR writeback ports (clear pending)
//   hi_*/lo_*                    : HI/LO special registers, no scoreboard
//   busy                         : registered pending vector, bit 0 always 0
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned NUM_RD    = DEF_NUM_RD,
  parameter int unsigned NUM_WR    = DEF_NUM_WR,
  parameter int unsigned BYPASS    = 1,
  parameter int unsigned INIT_MODE = INIT_INDEX
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic [NUM_WR-1:0]        alloc_en,
  input  logic [NUM_WR*ADDR_W-1:0] alloc_addr,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     hi_we,
  input  logic                     lo_we,
  input  logic [DATA_W-1:0]        hi_wdata,
  input  logic [DATA_W-1:0]        lo_wdata,
  input  logic                     hi_re,
  input  logic                     lo_re,
  output logic [DATA_W-1:0]        hi_rdata,
  output logic [DATA_W-1:0]        lo_rdata,
  output logic [2**ADDR_W-1:0]     busy
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [Depth];
  logic [Depth-1:0]  pending_q, pending_d;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic [NUM_RD-1:0] rd_hit;

  // Register array. Later ports override earlier ones through NBA ordering.
  always_ff @(posedge clk) begin
    if (rst_) begin
      for (int i = 0; i < int'(Depth); i++) begin
        regs_q[i] <= (INIT_MODE == INIT_INDEX) ? DATA_W'(i) : '0;
      end
    end else begin
      for (int k = 0; k < int'(NUM_WR); k++) begin
        if (wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] != '0)) begin
          regs_q[wr_addr[k*ADDR_W +: ADDR_W]] <= wr_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Writeback clears first, then allocates set: an allocate is younger than a
  // same-cycle writeback to the same register.
  always_comb begin
    pending_d = pending_q;
    for (int k = 0; k < int'(NUM_WR); k++) begin
      if (wr_en[k]) pending_d[wr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
    end
    for (int k = 0; k < int'(NUM_WR); k++) begin
      if (alloc_en[k]) pending_d[alloc_addr[k*ADDR_W +: ADDR_W]] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      pending_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      pending_q <= pending_d;
      if (hi_we) hi_q <= hi_wdata;
      if (lo_we) lo_q <= lo_wdata;
    end
  end

  assign busy = pending_q;

  always_comb begin
    hi_rdata = '0;
    lo_rdata = '0;
    if (hi_re) hi_rdata = ((BYPASS != 0) && hi_we) ? hi_wdata : hi_q;
    if (lo_re) lo_rdata = ((BYPASS != 0) && lo_we) ? lo_wdata : lo_q;
  end

  for (genvar r = 0; r < int'(NUM_RD); r++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = rd_addr[r*ADDR_W +: ADDR_W];

    regfile_rd_bypass #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR),
      .BYPASS (BYPASS)
    ) u_rd (
      .rd_en    (rd_en[r]),
      .rd_addr  (addr),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .arr_data (regs_q[addr]),
      .pending  (pending_q[addr]),
      .rd_data  (rd_data[r*DATA_W +: DATA_W]),
      .rd_valid (rd_valid[r]),
      .hit      (rd_hit[r])
    );

    // A bypassed operand is always ready when the port is enabled.
    assert property (@(posedge clk) disable iff (rst_) rd_hit[r] |-> (rd_valid[r] || !rd_en[r]));
  end

endmodule
